shared_port_mux: RTL and testbench

Downstream consumer of the round-robin arbiter's one-hot grant. Latches the granted requester's command, drives one burst onto the single shared memory port, and routes read data back to that requester. Pulses a per-requester done so the requester drops its request, which advances the arbiter. Never reacts to the same grant twice.

---
 rtl/shared_port_mux_if.sv | 42 ++++
 rtl/shared_port_mux.sv | 155 +++++++++++++++
 tb/tb_shared_port_mux.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_port_mux_if.sv
// Bundle of requester-side and memory-side signals around shared_port_mux.
// Signal names keep their i_/o_ prefixes as seen from the mux itself.
interface shared_port_mux_if #(
  parameter int N_REQ = 8,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int LEN_W = 4
);
  logic [N_REQ-1:0]       i_grant;
  logic [N_REQ*AW-1:0]    i_req_addr;
  logic [N_REQ-1:0]       i_req_we;
  logic [N_REQ*LEN_W-1:0] i_req_len;
  logic [N_REQ*DW-1:0]    i_req_wdata;
  logic [N_REQ-1:0]       o_beat_ack;
  logic [N_REQ-1:0]       o_rvalid;
  logic [DW-1:0]          o_rdata;
  logic [N_REQ-1:0]       o_done;
  logic                   o_grant_err;
  logic                   o_mem_valid;
  logic                   i_mem_ready;
  logic [AW-1:0]          o_mem_addr;
  logic                   o_mem_we;
  logic [DW-1:0]          o_mem_wdata;
  logic                   i_mem_rvalid;
  logic [DW-1:0]          i_mem_rdata;

  // The mux itself
  modport slave (
    input  i_grant, i_req_addr, i_req_we, i_req_len, i_req_wdata,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_beat_ack, o_rvalid, o_rdata, o_done, o_grant_err,
    output o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata
  );

  // Whatever surrounds the mux: arbiter, requesters and memory
  modport master (
    output i_grant, i_req_addr, i_req_we, i_req_len, i_req_wdata,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_beat_ack, o_rvalid, o_rdata, o_done, o_grant_err,
    input  o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/shared_port_mux.sv
// Takes the arbiter's one-hot grant, latches that requester's burst command,
// runs the burst on the single memory port, steers read data back and pulses
// a per-requester done. A finished grant is never serviced twice: the block
// parks in RELEASE until the arbiter shows something different.
module shared_port_mux #(
  parameter int N_REQ = 8,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int LEN_W = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  shared_port_mux_if.slave bus
);

  localparam int CW = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DONE,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [N_REQ-1:0] r_grant;
  logic [AW-1:0]    r_addr;
  logic             r_we;
  logic [LEN_W-1:0] r_len;
  logic [CW-1:0]    r_beat_cnt;
  logic [CW-1:0]    r_rsp_cnt;

  logic [AW-1:0]    w_sel_addr;
  logic             w_sel_we;
  logic [LEN_W-1:0] w_sel_len;
  logic [DW-1:0]    w_cur_wdata;
  logic             w_grant_nonzero;
  logic             w_grant_onehot;
  logic             w_handshake;
  logic             w_rsp;
  logic             w_last_beat;
  logic             w_last_rsp;

  assign w_grant_nonzero = |bus.i_grant;
  assign w_grant_onehot  = w_grant_nonzero &&
                           ((bus.i_grant & (bus.i_grant - N_REQ'(1))) == '0);
  assign w_handshake     = (r_state == S_ISSUE) && bus.i_mem_ready;
  // Responses only belong to a read burst; anything else is stray and dropped
  assign w_rsp           = ((r_state == S_ISSUE) || (r_state == S_WAIT_RSP)) &&
                           !r_we && bus.i_mem_rvalid;
  assign w_last_beat     = (r_beat_cnt == {1'b0, r_len});
  assign w_last_rsp      = w_rsp && (r_rsp_cnt == {1'b0, r_len});

  // Pick the granted requester's command fields and the latched requester's write word
  always_comb begin
    w_sel_addr  = '0;
    w_sel_we    = 1'b0;
    w_sel_len   = '0;
    w_cur_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (bus.i_grant[k]) begin
        w_sel_addr = w_sel_addr | bus.i_req_addr[k*AW +: AW];
        w_sel_we   = w_sel_we   | bus.i_req_we[k];
        w_sel_len  = w_sel_len  | bus.i_req_len[k*LEN_W +: LEN_W];
      end
      if (r_grant[k]) begin
        w_cur_wdata = w_cur_wdata | bus.i_req_wdata[k*DW +: DW];
      end
    end
  end

  // Next-state logic for the burst sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_onehot) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (r_we) begin
          if (w_handshake && w_last_beat) w_next_state = S_DONE;
        end else if (w_last_rsp) begin
          w_next_state = S_DONE;
        end else if (w_handshake && w_last_beat) begin
          w_next_state = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (w_last_rsp) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (bus.i_grant != r_grant) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, command latch and beat/response counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_rsp_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && w_grant_onehot) begin
        r_grant    <= bus.i_grant;
        r_addr     <= w_sel_addr;
        r_we       <= w_sel_we;
        r_len      <= w_sel_len;
        r_beat_cnt <= '0;
        r_rsp_cnt  <= '0;
      end else begin
        if (w_handshake) r_beat_cnt <= r_beat_cnt + CW'(1);
        if (w_rsp)       r_rsp_cnt  <= r_rsp_cnt + CW'(1);
      end
    end
  end

  // Memory command, acks, read return and status pulses, all decoded from state
  always_comb begin
    bus.o_mem_valid = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_wdata = '0;
    bus.o_beat_ack  = '0;
    bus.o_rvalid    = '0;
    bus.o_rdata     = '0;
    bus.o_done      = '0;
    bus.o_grant_err = 1'b0;
    if (r_state == S_ISSUE) begin
      bus.o_mem_valid = 1'b1;
      bus.o_mem_addr  = r_addr + AW'(r_beat_cnt);
      bus.o_mem_we    = r_we;
      bus.o_mem_wdata = w_cur_wdata;
      if (bus.i_mem_ready && r_we) bus.o_beat_ack = r_grant;
    end
    if (w_rsp) begin
      bus.o_rvalid = r_grant;
      bus.o_rdata  = bus.i_mem_rdata;
    end
    if (r_state == S_DONE) bus.o_done = r_grant;
    if ((r_state == S_IDLE) && w_grant_nonzero && !w_grant_onehot) bus.o_grant_err = 1'b1;
  end

endmodule

// File: tb/tb_shared_port_mux.sv
// Bench for shared_port_mux: directed bursts from the test plan followed by
// randomized bursts, each checked cycle by cycle against a burst-level model
// (beats issued, responses outstanding, when done is due).
module tb_shared_port_mux;
  localparam int N_REQ = 8;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [AW-1:0]    reqAddr  [N_REQ];
  logic             reqWe    [N_REQ];
  logic [LEN_W-1:0] reqLen   [N_REQ];
  logic [DW-1:0]    reqWdata [N_REQ];

  always #5 clk = ~clk;

  shared_port_mux_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .LEN_W(LEN_W)) busIf ();

  shared_port_mux #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (busIf)
  );

  // Copy the per-requester arrays onto the packed request buses
  task automatic applyStimulus();
    for (int k = 0; k < N_REQ; k++) begin
      busIf.i_req_addr[k*AW +: AW]        = reqAddr[k];
      busIf.i_req_we[k]                   = reqWe[k];
      busIf.i_req_len[k*LEN_W +: LEN_W]   = reqLen[k];
      busIf.i_req_wdata[k*DW +: DW]       = reqWdata[k];
    end
  endtask

  // One comparison: count it, and report it if it does not hold
  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic randomizeSlices();
    for (int k = 0; k < N_REQ; k++) begin
      reqAddr[k]  = AW'($urandom);
      reqWe[k]    = 1'($urandom);
      reqLen[k]   = LEN_W'($urandom);
      reqWdata[k] = $urandom;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // With the grant forced to zero the block is (or returns to) IDLE
  task automatic idleGap();
    busIf.i_grant      = '0;
    busIf.i_mem_ready  = 1'($urandom);
    busIf.i_mem_rvalid = 1'b0;
    applyStimulus();
    #1;
    checkOutput("gap_mem_valid", 32'(busIf.o_mem_valid), 32'd0);
    nextCycle();
  endtask

  // Run one burst for requester idx; cycle 0 is the cycle the new grant is shown.
  // startDelay is 1 from IDLE, 2 when the grant switches while the block sits in RELEASE.
  task automatic doBurst(int idx, bit we, int len, logic [AW-1:0] base, int stall,
                         int lat, int dropAt, int hold, int startDelay);
    logic [DW-1:0]    words[$];
    int               respDue[$];
    int               beats;
    int               rsps;
    int               stallCnt;
    int               doneCycle;
    bit               finished;
    bit               expValid;
    bit               rdyNow;
    bit               rvNow;
    logic [DW-1:0]    rdNow;
    logic [N_REQ-1:0] oneHot;
    logic [N_REQ-1:0] grantNow;
    logic [AW-1:0]    expAddr;
    beats     = 0;
    rsps      = 0;
    stallCnt  = 0;
    doneCycle = -1;
    finished  = 1'b0;
    oneHot    = N_REQ'(1) << idx;
    grantNow  = oneHot;
    randomizeSlices();
    reqAddr[idx] = base;
    reqWe[idx]   = we;
    reqLen[idx]  = LEN_W'(len);
    for (int b = 0; b <= len; b++) words.push_back($urandom);

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc == dropAt) grantNow = '0;
      expValid = (cyc >= startDelay) && (beats <= len);
      rdyNow   = expValid ? (stallCnt >= stall) : 1'($urandom);
      rvNow    = !we && (respDue.size() > 0) && (respDue[0] == cyc);
      rdNow    = $urandom;
      for (int k = 0; k < N_REQ; k++) reqWdata[k] = $urandom;
      if (beats <= len) reqWdata[idx] = words[beats];
      busIf.i_grant      = grantNow;
      busIf.i_mem_ready  = rdyNow;
      busIf.i_mem_rvalid = rvNow;
      busIf.i_mem_rdata  = rdNow;
      applyStimulus();
      #1;
      checkOutput("mem_valid", 32'(busIf.o_mem_valid), 32'(expValid));
      if (expValid) begin
        expAddr = base + AW'(beats);
        checkOutput("mem_addr", 32'(busIf.o_mem_addr), 32'(expAddr));
        checkOutput("mem_we", 32'(busIf.o_mem_we), 32'(we));
        checkOutput("mem_wdata", busIf.o_mem_wdata, reqWdata[idx]);
      end
      checkOutput("beat_ack", 32'(busIf.o_beat_ack), (expValid && rdyNow && we) ? 32'(oneHot) : 32'd0);
      checkOutput("rvalid", 32'(busIf.o_rvalid), rvNow ? 32'(oneHot) : 32'd0);
      checkOutput("rdata", busIf.o_rdata, rvNow ? rdNow : 32'd0);
      checkOutput("done", 32'(busIf.o_done), (cyc == doneCycle) ? 32'(oneHot) : 32'd0);
      checkOutput("grant_err", 32'(busIf.o_grant_err), 32'd0);
      if (cyc == doneCycle) finished = 1'b1;

      // Burst-level model update for the edge that follows
      if (expValid) begin
        if (rdyNow) begin
          beats++;
          stallCnt = 0;
          if (!we) respDue.push_back(cyc + lat);
          else if (beats == len + 1) doneCycle = cyc + 1;
        end else begin
          stallCnt++;
        end
      end
      if (rvNow) begin
        void'(respDue.pop_front());
        rsps++;
        if (rsps == len + 1) doneCycle = cyc + 1;
      end
      nextCycle();
    end
    checkOutput("burst_completed", 32'(finished), 32'd1);

    // After done the old grant (or its absence) must not start anything
    for (int h = 0; h < hold; h++) begin
      busIf.i_grant      = grantNow;
      busIf.i_mem_ready  = 1'($urandom);
      busIf.i_mem_rvalid = 1'($urandom);
      busIf.i_mem_rdata  = $urandom;
      applyStimulus();
      #1;
      checkOutput("hold_mem_valid", 32'(busIf.o_mem_valid), 32'd0);
      checkOutput("hold_done", 32'(busIf.o_done), 32'd0);
      checkOutput("hold_rvalid", 32'(busIf.o_rvalid), 32'd0);
      nextCycle();
    end
  endtask

  // Hard stop in case anything above stops advancing
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test plan, then randomized bursts, then reset during a read
  initial begin
    int idx;
    rst                = 1'b1;
    busIf.i_grant      = '0;
    busIf.i_mem_ready  = 1'b0;
    busIf.i_mem_rvalid = 1'b1;
    busIf.i_mem_rdata  = $urandom;
    randomizeSlices();
    applyStimulus();
    @(negedge clk);
    nextCycle();
    #1;
    checkOutput("reset_mem_valid", 32'(busIf.o_mem_valid), 32'd0);
    checkOutput("reset_mem_addr", 32'(busIf.o_mem_addr), 32'd0);
    checkOutput("reset_rvalid", 32'(busIf.o_rvalid), 32'd0);
    checkOutput("reset_rdata", busIf.o_rdata, 32'd0);
    checkOutput("reset_done", 32'(busIf.o_done), 32'd0);
    @(negedge clk);
    rst                = 1'b0;
    busIf.i_mem_rvalid = 1'b0;

    $display("[TB] single-beat write");
    doBurst(2, 1'b1, 0, 16'h0010, 0, 1, -1, 0, 1);
    idleGap();

    $display("[TB] four-beat read, 3-cycle latency");
    doBurst(0, 1'b0, 3, 16'h0100, 0, 3, -1, 0, 1);
    idleGap();

    $display("[TB] backpressure with address wrap");
    doBurst(5, 1'b1, 2, 16'hFFFF, 2, 1, -1, 0, 1);
    idleGap();
    doBurst(1, 1'b0, 2, 16'hFFFF, 2, 2, -1, 0, 1);
    idleGap();

    $display("[TB] grant persistence then switch");
    doBurst(3, 1'b1, 1, 16'h0200, 0, 1, -1, 4, 1);
    doBurst(4, 1'b0, 2, 16'h0300, 0, 2, -1, 0, 2);
    idleGap();

    $display("[TB] grant dropped mid-burst");
    doBurst(6, 1'b1, 3, 16'h0400, 0, 1, 2, 2, 1);
    idleGap();

    $display("[TB] illegal grant");
    busIf.i_grant = 8'h06;
    applyStimulus();
    #1;
    checkOutput("illegal_grant_err", 32'(busIf.o_grant_err), 32'd1);
    checkOutput("illegal_mem_valid", 32'(busIf.o_mem_valid), 32'd0);
    nextCycle();
    busIf.i_grant = '0;
    #1;
    checkOutput("illegal_after_valid", 32'(busIf.o_mem_valid), 32'd0);
    checkOutput("illegal_after_err", 32'(busIf.o_grant_err), 32'd0);
    nextCycle();

    $display("[TB] randomized bursts");
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, N_REQ - 1);
      doBurst(idx, 1'($urandom), $urandom_range(0, 15), AW'($urandom),
              $urandom_range(0, 2), $urandom_range(1, 4),
              ($urandom_range(0, 3) == 0) ? 1 + $urandom_range(0, 3) : -1,
              $urandom_range(0, 3), 1);
      idleGap();
    end

    $display("[TB] reset during read response wait");
    randomizeSlices();
    reqAddr[1] = 16'h2000;
    reqWe[1]   = 1'b0;
    reqLen[1]  = 4'd3;
    busIf.i_grant      = 8'h02;
    busIf.i_mem_ready  = 1'b1;
    busIf.i_mem_rvalid = 1'b0;
    applyStimulus();
    nextCycle();
    for (int b = 0; b < 4; b++) begin
      #1;
      checkOutput("rstread_issue_valid", 32'(busIf.o_mem_valid), 32'd1);
      checkOutput("rstread_issue_addr", 32'(busIf.o_mem_addr), 32'h2000 + 32'(b));
      nextCycle();
    end
    #1;
    checkOutput("rstread_wait_valid", 32'(busIf.o_mem_valid), 32'd0);
    rst = 1'b1;
    nextCycle();
    rst                = 1'b0;
    busIf.i_grant      = '0;
    busIf.i_mem_rvalid = 1'b1;
    busIf.i_mem_rdata  = $urandom;
    #1;
    checkOutput("rstread_mem_valid", 32'(busIf.o_mem_valid), 32'd0);
    checkOutput("rstread_mem_addr", 32'(busIf.o_mem_addr), 32'd0);
    checkOutput("rstread_mem_we", 32'(busIf.o_mem_we), 32'd0);
    checkOutput("rstread_mem_wdata", busIf.o_mem_wdata, 32'd0);
    checkOutput("rstread_beat_ack", 32'(busIf.o_beat_ack), 32'd0);
    checkOutput("rstread_rvalid", 32'(busIf.o_rvalid), 32'd0);
    checkOutput("rstread_rdata", busIf.o_rdata, 32'd0);
    checkOutput("rstread_done", 32'(busIf.o_done), 32'd0);
    checkOutput("rstread_grant_err", 32'(busIf.o_grant_err), 32'd0);
    nextCycle();
    #1;
    checkOutput("rstread_late_rvalid", 32'(busIf.o_rvalid), 32'd0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
